core_daddr_utlb: RTL and testbench
==================================

# core_daddr_utlb

Data-side address translation stage between M0 address generation and M1 memory access. It resolves direct-address (DA) and DMW0/DMW1 windows combinationally in M0. Page-mapped accesses go through a fully associative micro-TLB of `ENTRY_NUM` entries, tracked per page rather than per 512 MB segment. On a micro-TLB miss it stalls M1, refills from the main TLB over a valid/ready request, and writes the result back into the micro-TLB.

## Interface
Parameters:
- `ENTRY_NUM`, default 4: micro-TLB entries; power of two, 2..16.
- `ENABLE_TLB`, default 1: when 0, no micro-TLB and no refill logic; mapped accesses return `found=0`.
- `SUPPORT_32_PADDR`, default 0: when 0, output `ppn[31:29]` is forced to 0 for DA and DMW results.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `valid_i`  in  1  M0 access valid.
- `vaddr_i`  in  32  M0 virtual address.
- `m1_stall_i`  in  1  M1 stall; M0→M1 registers hold while high.
- `ready_o`  out  1  M1 translation result is usable.
- `csr_i`  in  csr_t  CRMD, DMW0, DMW1.
- `flush_trans_i`  in  1  translation state changed (CSR/ASID write, TLB maintenance).
- `vppn_o`  out  20  refill lookup VPPN, equal to `vaddr_q[31:12]`.
- `tlb_req_valid_o`  out  1  refill request.
- `tlb_req_ready_i`  in  1  request accepted; `tlb_resp_i` is valid in the same cycle.
- `tlb_resp_i`  in  tlb_s_resp_t  main-TLB result.
- `tlb_raw_result_o`  out  tlb_s_resp_t  registered M1 translation result.

## Operation
Priority in M0 is DA, then DMW0, then DMW1, then micro-TLB.
- **DA:** `dmw=1`, `ppn=vaddr_i[31:12]`, `mat=CRMD.DATM`, `plv=CRMD.PLV`.
- **DMWn hit** (`vaddr_i[31:29]==DMWn.VSEG`): `dmw=1`, `ppn={DMWn.PSEG, vaddr_i[28:12]}`, `mat/plv` taken from DMWn.
- **DA and DMW results:** `found=v=d=1`, `ps=12`, `index=0`. Privilege checks happen in M1, not here.

Micro-TLB entry contents: `valid`, `vtag[31:12]`, and a stored `tlb_s_resp_t`.
- Match rule by stored page size:
  - `ps==12`: compare `[31:12]`.
  - `ps==21`: compare `[31:21]`.
  - `ps==22`: compare `[31:22]`.
- On multiple hits, the lowest index wins.
- A hit selects the stored response.
- When none of DA, DMW or an entry matches, M1 is marked `miss`.
- Invalid accesses (`valid_i=0`) never miss.

Refill state machine, `fsm_q`, reset to IDLE:
- **IDLE → REQ:** when the M1 result is a miss and `flush_trans_i=0`.
- **REQ:** `tlb_req_valid_o=1`. On `tlb_req_ready_i`:
  - load `tlb_resp_i` into the M1 result register;
  - clear the miss;
  - if `found=1`, write the entry: first invalid index, else round-robin pointer `rr_q`; `rr_q` increments (wraps at `ENTRY_NUM`) on each write;
  - if `found=0`, forward the response without caching it (TLB-refill exception downstream);
  - go to IDLE.
- **`flush_trans_i`** (any state):
  - clear all entry valid bits and return to IDLE;
  - an `rr_q` reset is not required;
  - if a response arrives in the same cycle as the flush, it is discarded and no entry is written;
  - an M1 access stalled across the flush re-misses and re-requests.

`ready_o = !miss_q`.

## Timing
Reset values:
- `ready_o=1`, `tlb_req_valid_o=0`, `vppn_o=0`, `tlb_raw_result_o='0`.
- All entries invalid, `rr_q=0`, `miss_q=0`.

Hit latency is 1 cycle: the result is registered at the clock edge where `m1_stall_i=0`.

Miss timing, with t = cycle `miss_q` rises:
- t: `ready_o=0`.
- t+1: `tlb_req_valid_o=1`.
- If ready is accepted at t+k, `ready_o=1` at t+k+1.
- Minimum penalty is 2 cycles.

Handshake rules:
- `vppn_o` is stable while `tlb_req_valid_o=1`.
- `tlb_req_valid_o` is never dropped without a handshake, except on flush or reset.

Stall behaviour:
- While `m1_stall_i=1` and no refill is in progress, the M1 registers hold their values.
- The external pipeline holds `m1_stall_i=1` whenever `ready_o=0`.

Reset mid-refill drops the request immediately.

## Structure
Shared package, alongside `tlb_s_resp_t`:
- `utlb_entry_t` (`valid`, `vtag`, `resp`);
- localparams `UTLB_IDLE` / `UTLB_REQ`.

One sub-module, `core_utlb_match`: per-entry page-size-masked tag compare producing `hit`. It is instantiated `ENTRY_NUM` times, with a priority one-hot→index encoder in the parent.

## Test plan
- **DMW hit:** DMW0 VSEG=4, PSEG=0, MAT=1 (`SUPPORT_32_PADDR=0`), `vaddr_i=0x8000_1234` → next cycle `ppn=0x00001`, `dmw=1`, `mat=1`, `ready_o=1`, no request.
- **Cold miss:**
  - Mapped `vaddr_i=0x0040_3000`, ready held at 1 → `vppn_o=0x00403` at t+1, `ready_o=1` at t+2.
  - Same address again → hit with no request.
- **Big page:** refill returns `ps=22`; then `vaddr_i=0x007F_F000` → hit from the same entry.
- **Replacement:** `ENTRY_NUM=4`, five distinct 4 KB pages → fifth fill overwrites entry 0; the first page then misses again.
- **Flush race:** `flush_trans_i` in the same cycle as `tlb_req_ready_i` → no entry written, FSM IDLE, new request 2 cycles later; `found=0` response → forwarded, not cached.
- **Async reset:** reset asserted mid-REQ → `tlb_req_valid_o` is 0 before the next clock edge and all outputs take their reset values.

Source files
------------

// File: rtl/core_daddr_utlb_pkg.sv
// Shared types for the data-side translation stage: CSR views, main-TLB response, micro-TLB entry.
// Pure declarations and one helper; no timing or backpressure of its own.
// The helper builds the fixed-attribute result used by direct and window translations.
package core_daddr_utlb_pkg;

    typedef struct packed {
        logic       da;
        logic [1:0] datm;
        logic [1:0] plv;
    } crmd_t;

    // en gates the window; a cleared DMW would otherwise claim segment 0
    typedef struct packed {
        logic       en;
        logic [2:0] vseg;
        logic [2:0] pseg;
        logic [1:0] mat;
        logic [1:0] plv;
    } dmw_t;

    typedef struct packed {
        crmd_t crmd;
        dmw_t  dmw0;
        dmw_t  dmw1;
    } csr_t;

    typedef struct packed {
        logic        found;
        logic [3:0]  index;
        logic [5:0]  ps;
        logic [19:0] ppn;
        logic        v;
        logic        d;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic        dmw;
    } tlb_s_resp_t;

    typedef struct packed {
        logic        valid;
        logic [19:0] vtag;
        tlb_s_resp_t resp;
    } utlb_entry_t;

    typedef enum logic {
        UTLB_IDLE = 1'b0,
        UTLB_REQ  = 1'b1
    } utlb_state_e;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;
    localparam logic [5:0] PS_4M = 6'd22;

    function automatic tlb_s_resp_t direct_resp(input logic [19:0] ppn, input logic [1:0] mat,
                                                input logic [1:0] plv, input logic keep_hi);
        tlb_s_resp_t r;
        r       = '0;
        r.found = 1'b1;
        r.v     = 1'b1;
        r.d     = 1'b1;
        r.dmw   = 1'b1;
        r.ps    = PS_4K;
        r.ppn   = {(keep_hi ? ppn[19:17] : 3'b000), ppn[16:0]};
        r.mat   = mat;
        r.plv   = plv;
        return r;
    endfunction

endpackage

// File: rtl/core_utlb_match.sv
// Page-size-masked tag compare for one micro-TLB entry.
// Purely combinational, zero latency.
// No backpressure; evaluated every cycle.
module core_utlb_match
    import core_daddr_utlb_pkg::*;
(
    input  logic        valid,
    input  logic [19:0] vtag,
    input  logic [5:0]  ps,
    input  logic [19:0] vpn,
    output logic        hit
);

    logic [19:0] mask;

    always_comb begin
        case (ps)
            PS_2M:   mask = 20'hFFE00;
            PS_4M:   mask = 20'hFFC00;
            default: mask = 20'hFFFFF;
        endcase
    end

    assign hit = valid && (((vpn ^ vtag) & mask) == 20'h0);

endmodule

// File: rtl/core_daddr_utlb.sv
// Data-side M0 translation (DA, DMW0/1, micro-TLB) registered into M1, with main-TLB refill on miss.
// Hit: 1 cycle. Miss: ready_o low from miss cycle until the edge after the refill handshake (>=2 cycles).
// Holds M1 while m1_stall_i or a refill is in flight; refill uses valid/ready, dropped only by flush/reset.
module core_daddr_utlb
    import core_daddr_utlb_pkg::*;
#(
    parameter int ENTRY_NUM        = 4,
    parameter int ENABLE_TLB       = 1,
    parameter int SUPPORT_32_PADDR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] vaddr_i,
    input  logic        m1_stall_i,
    output logic        ready_o,
    input  csr_t        csr_i,
    input  logic        flush_trans_i,
    output logic [19:0] vppn_o,
    output logic        tlb_req_valid_o,
    input  logic        tlb_req_ready_i,
    input  tlb_s_resp_t tlb_resp_i,
    output tlb_s_resp_t tlb_raw_result_o
);

    localparam int   IW      = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam logic TLB_ON  = (ENABLE_TLB != 0);
    localparam logic KEEP_HI = (SUPPORT_32_PADDR != 0);

    utlb_entry_t          entries_q [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] hit_vec;
    logic [IW-1:0]        hit_idx, wr_idx, rr_q;
    logic                 any_hit, dmw0_hit, dmw1_hit, m0_miss, refill;
    tlb_s_resp_t          m0_res, res_q;
    logic [19:0]          vpn_q;
    logic                 miss_q;
    utlb_state_e          fsm_q, fsm_d;
    logic                 unused_offset;

    assign unused_offset = ^vaddr_i[11:0];

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_match
        core_utlb_match u_match (
            .valid (entries_q[g].valid),
            .vtag  (entries_q[g].vtag),
            .ps    (entries_q[g].resp.ps),
            .vpn   (vaddr_i[31:12]),
            .hit   (hit_vec[g])
        );
    end

    // Lowest index wins on multiple hits; lowest invalid index is the preferred victim.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        wr_idx  = rr_q;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = IW'(i);
                any_hit = 1'b1;
            end
            if (!entries_q[i].valid) wr_idx = IW'(i);
        end
    end

    assign dmw0_hit = csr_i.dmw0.en && (vaddr_i[31:29] == csr_i.dmw0.vseg);
    assign dmw1_hit = csr_i.dmw1.en && (vaddr_i[31:29] == csr_i.dmw1.vseg);

    // Entries are about to be invalidated on flush, so a concurrent lookup must not trust them.
    always_comb begin
        m0_res  = '0;
        m0_miss = 1'b0;
        if (csr_i.crmd.da)
            m0_res = direct_resp(vaddr_i[31:12], csr_i.crmd.datm, csr_i.crmd.plv, KEEP_HI);
        else if (dmw0_hit)
            m0_res = direct_resp({csr_i.dmw0.pseg, vaddr_i[28:12]}, csr_i.dmw0.mat,
                                 csr_i.dmw0.plv, KEEP_HI);
        else if (dmw1_hit)
            m0_res = direct_resp({csr_i.dmw1.pseg, vaddr_i[28:12]}, csr_i.dmw1.mat,
                                 csr_i.dmw1.plv, KEEP_HI);
        else if (TLB_ON && any_hit && !flush_trans_i)
            m0_res = entries_q[hit_idx].resp;
        else
            m0_miss = TLB_ON && valid_i;
    end

    always_comb begin
        fsm_d           = fsm_q;
        tlb_req_valid_o = 1'b0;
        refill          = 1'b0;
        case (fsm_q)
            UTLB_IDLE: begin
                if (TLB_ON && miss_q && !flush_trans_i) fsm_d = UTLB_REQ;
            end
            UTLB_REQ: begin
                tlb_req_valid_o = 1'b1;
                if (flush_trans_i) begin
                    fsm_d = UTLB_IDLE;
                end else if (tlb_req_ready_i) begin
                    refill = 1'b1;
                    fsm_d  = UTLB_IDLE;
                end
            end
            default: fsm_d = UTLB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= UTLB_IDLE;
        else        fsm_q <= fsm_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            vpn_q  <= '0;
            miss_q <= 1'b0;
        end else if (refill) begin
            res_q  <= tlb_resp_i;
            miss_q <= 1'b0;
        end else if (fsm_q == UTLB_IDLE && !m1_stall_i) begin
            res_q  <= m0_res;
            vpn_q  <= vaddr_i[31:12];
            miss_q <= m0_miss;
        end
    end

    // Not-found responses are forwarded only; caching them would hide the refill exception.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) entries_q[i] <= '0;
            rr_q <= '0;
        end else if (flush_trans_i) begin
            for (int i = 0; i < ENTRY_NUM; i++) entries_q[i].valid <= 1'b0;
        end else if (refill && tlb_resp_i.found) begin
            entries_q[wr_idx].valid <= 1'b1;
            entries_q[wr_idx].vtag  <= vpn_q;
            entries_q[wr_idx].resp  <= tlb_resp_i;
            rr_q                    <= rr_q + IW'(1);
        end
    end

    assign ready_o          = !miss_q;
    assign vppn_o           = vpn_q;
    assign tlb_raw_result_o = res_q;

endmodule

// File: tb/tb_core_daddr_utlb.sv
// Directed checks of the data-side translation stage: windows, refill, page sizes, replacement, flush race, reset.
module tb_core_daddr_utlb;
    import core_daddr_utlb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] vaddr_i;
    logic        m1_stall_i;
    logic        ready_o;
    csr_t        csr_i;
    logic        flush_trans_i;
    logic [19:0] vppn_o;
    logic        tlb_req_valid_o;
    logic        tlb_req_ready_i;
    tlb_s_resp_t tlb_resp_i;
    tlb_s_resp_t tlb_raw_result_o;

    int n_assert = 0;
    int n_fail   = 0;

    core_daddr_utlb #(.ENTRY_NUM(4), .ENABLE_TLB(1), .SUPPORT_32_PADDR(0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_i          (valid_i),
        .vaddr_i          (vaddr_i),
        .m1_stall_i       (m1_stall_i),
        .ready_o          (ready_o),
        .csr_i            (csr_i),
        .flush_trans_i    (flush_trans_i),
        .vppn_o           (vppn_o),
        .tlb_req_valid_o  (tlb_req_valid_o),
        .tlb_req_ready_i  (tlb_req_ready_i),
        .tlb_resp_i       (tlb_resp_i),
        .tlb_raw_result_o (tlb_raw_result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic tlb_s_resp_t mk(input logic found, input logic [3:0] idx, input logic [5:0] ps,
                                       input logic [19:0] ppn, input logic v, input logic d,
                                       input logic [1:0] mat, input logic [1:0] plv, input logic dmw);
        tlb_s_resp_t r;
        r.found = found; r.index = idx; r.ps = ps; r.ppn = ppn;
        r.v = v; r.d = d; r.mat = mat; r.plv = plv; r.dmw = dmw;
        return r;
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_req_valid"}, 64'(tlb_req_valid_o), 64'd0);
        chk({tag, "_vppn"}, 64'(vppn_o), 64'd0);
        chk({tag, "_result"}, 64'(tlb_raw_result_o), 64'd0);
    endtask

    task automatic do_hit(input logic [31:0] va, input tlb_s_resp_t exp, input string tag);
        valid_i    = 1'b1;
        vaddr_i    = va;
        m1_stall_i = 1'b0;
        step();
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_no_req"}, 64'(tlb_req_valid_o), 64'd0);
        chk({tag, "_result"}, 64'(tlb_raw_result_o), 64'(exp));
    endtask

    // Miss cycle t, request at t+1 accepted immediately, result usable at t+2.
    task automatic do_miss(input logic [31:0] va, input tlb_s_resp_t rsp, input string tag);
        valid_i         = 1'b1;
        vaddr_i         = va;
        m1_stall_i      = 1'b0;
        tlb_resp_i      = rsp;
        tlb_req_ready_i = 1'b1;
        step();
        chk({tag, "_t_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_t_req"}, 64'(tlb_req_valid_o), 64'd0);
        m1_stall_i = 1'b1;
        step();
        chk({tag, "_t1_req"}, 64'(tlb_req_valid_o), 64'd1);
        chk({tag, "_t1_vppn"}, 64'(vppn_o), 64'(va[31:12]));
        step();
        chk({tag, "_t2_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_t2_req"}, 64'(tlb_req_valid_o), 64'd0);
        chk({tag, "_t2_result"}, 64'(tlb_raw_result_o), 64'(rsp));
        m1_stall_i      = 1'b0;
        tlb_req_ready_i = 1'b0;
    endtask

    initial begin
        tlb_s_resp_t r_small, r_big, r_fl;
        rst_n           = 1'b0;
        valid_i         = 1'b0;
        vaddr_i         = '0;
        m1_stall_i      = 1'b0;
        csr_i           = '0;
        flush_trans_i   = 1'b0;
        tlb_req_ready_i = 1'b0;
        tlb_resp_i      = '0;
        step();
        step();
        chk_reset_state("reset");
        rst_n = 1'b1;

        csr_i.dmw0.en = 1'b1; csr_i.dmw0.vseg = 3'd4; csr_i.dmw0.pseg = 3'd0;
        csr_i.dmw0.mat = 2'd1; csr_i.dmw0.plv = 2'd0;
        csr_i.dmw1.en = 1'b1; csr_i.dmw1.vseg = 3'd5; csr_i.dmw1.pseg = 3'd7;
        csr_i.dmw1.mat = 2'd2; csr_i.dmw1.plv = 2'd3;
        do_hit(32'h8000_1234, mk(1, 4'd0, 6'd12, 20'h00001, 1, 1, 2'd1, 2'd0, 1), "dmw0");
        do_hit(32'hA000_5000, mk(1, 4'd0, 6'd12, 20'h00005, 1, 1, 2'd2, 2'd3, 1), "dmw1");
        csr_i.crmd.da = 1'b1; csr_i.crmd.datm = 2'd0; csr_i.crmd.plv = 2'd3;
        do_hit(32'hA123_4000, mk(1, 4'd0, 6'd12, 20'h01234, 1, 1, 2'd0, 2'd3, 1), "da");
        csr_i.crmd = '0;

        r_small = mk(1, 4'd3, 6'd12, 20'h12345, 1, 0, 2'd1, 2'd3, 0);
        do_miss(32'h0040_3000, r_small, "cold");
        do_hit(32'h0040_3FFC, r_small, "cold_hit");

        r_big = mk(1, 4'd5, 6'd22, 20'h00400, 1, 1, 2'd1, 2'd0, 0);
        do_miss(32'h0040_0000, r_big, "big");
        do_hit(32'h007F_F000, r_big, "big_hit");
        do_hit(32'h0040_3000, r_small, "prio_low");

        valid_i = 1'b0;
        vaddr_i = 32'h0900_0000;
        step();
        chk("invalid_ready", 64'(ready_o), 64'd1);
        step();
        chk("invalid_no_req", 64'(tlb_req_valid_o), 64'd0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            do_miss(32'h1000_0000 + 32'(i) * 32'h1000,
                    mk(1, 4'(i), 6'd12, 20'h00100 + 20'(i), 1, 1, 2'd1, 2'd0, 0), "fill");
        do_hit(32'h1000_1000, mk(1, 4'd1, 6'd12, 20'h00101, 1, 1, 2'd1, 2'd0, 0), "repl_keep1");
        do_hit(32'h1000_4000, mk(1, 4'd4, 6'd12, 20'h00104, 1, 1, 2'd1, 2'd0, 0), "repl_new");

        valid_i = 1'b1;
        vaddr_i = 32'h1000_0000;
        step();
        chk("evicted_miss", 64'(ready_o), 64'd0);
        m1_stall_i = 1'b1;
        step();
        chk("race_req", 64'(tlb_req_valid_o), 64'd1);
        step();
        chk("race_req_held", 64'(tlb_req_valid_o), 64'd1);
        chk("race_vppn_stable", 64'(vppn_o), 64'h10000);

        r_fl            = mk(1, 4'd2, 6'd12, 20'h0BEEF, 1, 1, 2'd1, 2'd0, 0);
        tlb_resp_i      = r_fl;
        tlb_req_ready_i = 1'b1;
        flush_trans_i   = 1'b1;
        step();
        flush_trans_i   = 1'b0;
        tlb_req_ready_i = 1'b0;
        chk("flush_still_miss", 64'(ready_o), 64'd0);
        chk("flush_idle", 64'(tlb_req_valid_o), 64'd0);
        chk("flush_result_kept", 64'(tlb_raw_result_o), 64'd0);
        step();
        chk("flush_rereq", 64'(tlb_req_valid_o), 64'd1);
        chk("flush_rereq_vppn", 64'(vppn_o), 64'h10000);

        tlb_resp_i      = mk(0, 4'd0, 6'd12, 20'h0, 0, 0, 2'd0, 2'd0, 0);
        tlb_req_ready_i = 1'b1;
        step();
        tlb_req_ready_i = 1'b0;
        chk("nf_ready", 64'(ready_o), 64'd1);
        chk("nf_forward", 64'(tlb_raw_result_o), 64'(mk(0, 4'd0, 6'd12, 20'h0, 0, 0, 2'd0, 2'd0, 0)));
        m1_stall_i = 1'b0;
        step();
        chk("nf_not_cached", 64'(ready_o), 64'd0);
        m1_stall_i = 1'b1;
        step();
        chk("pre_reset_req", 64'(tlb_req_valid_o), 64'd1);

        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        step();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
